// File: rtl/scarv_ccx_memif_arb.sv
// Two-requester arbiter sharing one CCX memory bus target, round-robin by default.
// Define SCARV_CCX_ARB_FIXED_PRIO_EN to make requester 0 win every unlocked contention.
module scarv_ccx_memif_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            g_clk,
  input  logic            g_resetn,

  input  logic            s0_req,
  input  logic            s0_wen,
  input  logic [DW/8-1:0] s0_strb,
  input  logic [DW-1:0]   s0_wdata,
  input  logic [AW-1:0]   s0_addr,
  output logic            s0_gnt,
  output logic            s0_error,
  output logic [DW-1:0]   s0_rdata,

  input  logic            s1_req,
  input  logic            s1_wen,
  input  logic [DW/8-1:0] s1_strb,
  input  logic [DW-1:0]   s1_wdata,
  input  logic [AW-1:0]   s1_addr,
  output logic            s1_gnt,
  output logic            s1_error,
  output logic [DW-1:0]   s1_rdata,

  output logic            m_req,
  output logic            m_wen,
  output logic [DW/8-1:0] m_strb,
  output logic [DW-1:0]   m_wdata,
  output logic [AW-1:0]   m_addr,
  input  logic            m_gnt,
  input  logic            m_error,
  input  logic [DW-1:0]   m_rdata
);

  logic locked_q, locked_d;
  logic owner_q,  owner_d;
  logic last_q,   last_d;
  logic rsp_v_q,  rsp_v_d;
  logic rsp_id_q, rsp_id_d;

  logic sel;
  logic xfer;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      locked_q <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      rsp_v_q  <= 1'b0;
      rsp_id_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      rsp_v_q  <= rsp_v_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  // A locked selection is never re-arbitrated, even if the owner misbehaves.
  always_comb begin
    sel = last_q;
    if (locked_q) begin
      sel = owner_q;
    end else if (s0_req && !s1_req) begin
      sel = 1'b0;
    end else if (s1_req && !s0_req) begin
      sel = 1'b1;
    end else if (s0_req && s1_req) begin
`ifdef SCARV_CCX_ARB_FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = ~last_q;
`endif
    end
  end

  always_comb begin
    if (sel) begin
      m_req   = s1_req;
      m_wen   = s1_wen;
      m_strb  = s1_strb;
      m_wdata = s1_wdata;
      m_addr  = s1_addr;
    end else begin
      m_req   = s0_req;
      m_wen   = s0_wen;
      m_strb  = s0_strb;
      m_wdata = s0_wdata;
      m_addr  = s0_addr;
    end
  end

  assign xfer = m_req & m_gnt;

  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    last_d   = last_q;
    rsp_v_d  = xfer;
    rsp_id_d = rsp_id_q;
    if (m_req && !m_gnt) begin
      locked_d = 1'b1;
      owner_d  = sel;
    end
    if (xfer) begin
      locked_d = 1'b0;
      last_d   = sel;
      rsp_id_d = sel;
    end
  end

  // Read data is broadcast; only the error strobe is steered to the granted side.
  always_comb begin
    s0_gnt   = xfer & (sel == 1'b0);
    s1_gnt   = xfer & (sel == 1'b1);
    s0_error = m_error & rsp_v_q & (rsp_id_q == 1'b0);
    s1_error = m_error & rsp_v_q & (rsp_id_q == 1'b1);
    s0_rdata = m_rdata;
    s1_rdata = m_rdata;
  end

endmodule

// File: tb/tb_scarv_ccx_memif_arb.sv
// Self-checking bench for scarv_ccx_memif_arb: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbiter.
module tb_scarv_ccx_memif_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          g_clk = 1'b0;
  logic          g_resetn;
  logic          s0_req, s0_wen, s0_gnt, s0_error;
  logic [SW-1:0] s0_strb;
  logic [DW-1:0] s0_wdata, s0_rdata;
  logic [AW-1:0] s0_addr;
  logic          s1_req, s1_wen, s1_gnt, s1_error;
  logic [SW-1:0] s1_strb;
  logic [DW-1:0] s1_wdata, s1_rdata;
  logic [AW-1:0] s1_addr;
  logic          m_req, m_wen, m_gnt, m_error;
  logic [SW-1:0] m_strb;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [AW-1:0] m_addr;

  int tests = 0;
  int fails = 0;

  always #5 g_clk = ~g_clk;

  scarv_ccx_memif_arb #(.AW(AW), .DW(DW)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .s0_req(s0_req), .s0_wen(s0_wen), .s0_strb(s0_strb), .s0_wdata(s0_wdata),
    .s0_addr(s0_addr), .s0_gnt(s0_gnt), .s0_error(s0_error), .s0_rdata(s0_rdata),
    .s1_req(s1_req), .s1_wen(s1_wen), .s1_strb(s1_strb), .s1_wdata(s1_wdata),
    .s1_addr(s1_addr), .s1_gnt(s1_gnt), .s1_error(s1_error), .s1_rdata(s1_rdata),
    .m_req(m_req), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata),
    .m_addr(m_addr), .m_gnt(m_gnt), .m_error(m_error), .m_rdata(m_rdata)
  );

  task automatic idle_inputs();
    s0_req = 0; s0_wen = 0; s0_strb = '0; s0_wdata = '0; s0_addr = '0;
    s1_req = 0; s1_wen = 0; s1_strb = '0; s1_wdata = '0; s1_addr = '0;
    m_gnt = 0; m_error = 0; m_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge g_clk);
    g_resetn = 0;
    idle_inputs();
    @(negedge g_clk);
    g_resetn = 1;
  endtask

  task automatic test_reset();
    @(negedge g_clk);
    g_resetn = 0;
    idle_inputs();
    m_error = 1;
    #1;
    tests++; if (m_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_req got %b want 0", m_req); end
    tests++; if ({s0_error, s1_error} !== 2'b00) begin fails++; $display("[TB] FAIL reset_error got %b want 00", {s0_error, s1_error}); end
    @(negedge g_clk);
    s1_req = 1; m_gnt = 1;
    #1;
    tests++; if ({s1_gnt, s0_gnt, m_req} !== 3'b101) begin fails++; $display("[TB] FAIL reset_comb_gnt got %b want 101", {s1_gnt, s0_gnt, m_req}); end
    @(negedge g_clk);
    idle_inputs();
    g_resetn = 1;
  endtask

  task automatic test_single_grant();
    logic [DW-1:0] rd;
    do_reset();
    s0_req = 1; s0_addr = 32'h100; m_gnt = 1;
    #1;
    tests++; if (m_req !== 1'b1) begin fails++; $display("[TB] FAIL single_m_req got %b want 1", m_req); end
    tests++; if (m_addr !== 32'h100) begin fails++; $display("[TB] FAIL single_m_addr got %h want 00000100", m_addr); end
    tests++; if ({s0_gnt, s1_gnt} !== 2'b10) begin fails++; $display("[TB] FAIL single_gnt got %b want 10", {s0_gnt, s1_gnt}); end
    @(negedge g_clk);
    rd = $urandom;
    s0_req = 0; m_gnt = 0; m_error = 1; m_rdata = rd;
    #1;
    tests++; if ({s0_error, s1_error} !== 2'b10) begin fails++; $display("[TB] FAIL single_error got %b want 10", {s0_error, s1_error}); end
    tests++; if (s0_rdata !== rd || s1_rdata !== rd) begin fails++; $display("[TB] FAIL single_rdata got %h/%h want %h", s0_rdata, s1_rdata, rd); end
    @(negedge g_clk);
    m_error = 0;
  endtask

  task automatic test_round_robin();
    logic [1:0] want;
    do_reset();
    s0_req = 1; s0_addr = 32'hA0; s1_req = 1; s1_addr = 32'hB0; m_gnt = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef SCARV_CCX_ARB_FIXED_PRIO_EN
      want = 2'b10;
`else
      want = (i % 2 == 0) ? 2'b10 : 2'b01;
`endif
      #1;
      tests++; if ({s0_gnt, s1_gnt} !== want) begin fails++; $display("[TB] FAIL rr_gnt%0d got %b want %b", i, {s0_gnt, s1_gnt}, want); end
      @(negedge g_clk);
    end
    idle_inputs();
  endtask

  task automatic test_lock_hold();
    do_reset();
    s1_req = 1; s1_addr = 32'h200; m_gnt = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) begin s0_req = 1; s0_addr = 32'h300; end
      #1;
      tests++; if (m_addr !== 32'h200 || s0_gnt !== 1'b0) begin fails++; $display("[TB] FAIL lock_hold%0d got addr %h s0_gnt %b want 00000200 0", c, m_addr, s0_gnt); end
      @(negedge g_clk);
    end
    m_gnt = 1;
    #1;
    tests++; if ({s0_gnt, s1_gnt} !== 2'b01) begin fails++; $display("[TB] FAIL lock_release got %b want 01", {s0_gnt, s1_gnt}); end
    @(negedge g_clk);
    s1_addr = 32'h210;
    #1;
    tests++; if ({s0_gnt, s1_gnt} !== 2'b10 || m_addr !== 32'h300) begin fails++; $display("[TB] FAIL lock_next got %b addr %h want 10 00000300", {s0_gnt, s1_gnt}, m_addr); end
    @(negedge g_clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    s0_req = 1; s0_addr = 32'h10; m_gnt = 1;
    #1;
    tests++; if ({s0_gnt, s1_gnt} !== 2'b10) begin fails++; $display("[TB] FAIL b2b_t got %b want 10", {s0_gnt, s1_gnt}); end
    @(negedge g_clk);
    s0_req = 0; s1_req = 1; s1_addr = 32'h20; m_error = 0;
    #1;
    tests++; if ({s0_gnt, s1_gnt, s0_error, s1_error} !== 4'b0100) begin fails++; $display("[TB] FAIL b2b_t1 got %b want 0100", {s0_gnt, s1_gnt, s0_error, s1_error}); end
    @(negedge g_clk);
    s1_req = 0; m_gnt = 0; m_error = 1;
    #1;
    tests++; if ({s0_error, s1_error} !== 2'b01) begin fails++; $display("[TB] FAIL b2b_t2 got %b want 01", {s0_error, s1_error}); end
    @(negedge g_clk);
    #1;
    tests++; if ({s0_error, s1_error} !== 2'b00) begin fails++; $display("[TB] FAIL b2b_t3 got %b want 00", {s0_error, s1_error}); end
    @(negedge g_clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    s1_req = 1; s1_addr = 32'h44; m_gnt = 1;
    @(negedge g_clk);
    g_resetn = 0; m_gnt = 0; m_error = 1;
    #1;
    tests++; if ({s0_error, s1_error} !== 2'b00) begin fails++; $display("[TB] FAIL rst_inflight got %b want 00", {s0_error, s1_error}); end
    @(negedge g_clk);
    g_resetn = 1; m_error = 0;
    @(negedge g_clk);
    @(negedge g_clk);
    g_resetn = 0;
    @(negedge g_clk);
    g_resetn = 1; s0_req = 1; s0_addr = 32'h55; m_gnt = 1; m_error = 1;
    #1;
    tests++; if ({s0_gnt, s1_gnt} !== 2'b10) begin fails++; $display("[TB] FAIL rst_unlock got %b want 10", {s0_gnt, s1_gnt}); end
    tests++; if ({s0_error, s1_error} !== 2'b00) begin fails++; $display("[TB] FAIL rst_spurious got %b want 00", {s0_error, s1_error}); end
    @(negedge g_clk);
    idle_inputs();
  endtask

  task automatic test_write_payload();
    do_reset();
    s0_wen = 0; s0_strb = 4'b1100; s0_wdata = 32'h12345678; s0_addr = 32'h400;
    s1_req = 1; s1_wen = 1; s1_strb = 4'b0011; s1_wdata = 32'hDEADBEEF; s1_addr = 32'h500;
    m_gnt = 1;
    #1;
    tests++; if ({m_wen, m_strb} !== 5'b10011) begin fails++; $display("[TB] FAIL wr_ctrl got %b want 10011", {m_wen, m_strb}); end
    tests++; if (m_wdata !== 32'hDEADBEEF || m_addr !== 32'h500) begin fails++; $display("[TB] FAIL wr_data got %h@%h want deadbeef@00000500", m_wdata, m_addr); end
    @(negedge g_clk);
    idle_inputs();
  endtask

  // Model: each side has at most one pending transaction; a stalled winner is held,
  // contention goes to the side served least recently (or side 0 in fixed mode).
  task automatic test_random();
    bit            pend[2];
    logic          p_wen[2];
    logic [SW-1:0] p_strb[2];
    logic [DW-1:0] p_wdata[2];
    logic [AW-1:0] p_addr[2];
    bit            held, held_id, served_last, rsp_due, rsp_who, has;
    int            w;
    logic [1:0]    exp_gnt, exp_err;
    do_reset();
    pend = '{0, 0}; held = 0; held_id = 0; served_last = 1; rsp_due = 0; rsp_who = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && ($urandom_range(2, 0) != 0)) begin
          pend[n] = 1;
          p_wen[n] = 1'($urandom_range(1, 0));
          p_strb[n] = SW'($urandom_range(15, 0));
          p_wdata[n] = $urandom;
          p_addr[n] = $urandom;
        end
      end
      s0_req = pend[0]; s0_wen = p_wen[0]; s0_strb = p_strb[0]; s0_wdata = p_wdata[0]; s0_addr = p_addr[0];
      s1_req = pend[1]; s1_wen = p_wen[1]; s1_strb = p_strb[1]; s1_wdata = p_wdata[1]; s1_addr = p_addr[1];
      m_gnt = ($urandom_range(3, 0) != 0);
      m_error = 1'($urandom_range(1, 0));
      m_rdata = $urandom;
      has = pend[0] || pend[1];
      if (held) w = int'(held_id);
      else if (pend[0] && pend[1]) begin
`ifdef SCARV_CCX_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = served_last ? 0 : 1;
`endif
      end
      else w = pend[1] ? 1 : 0;
      exp_gnt = 2'b00;
      if (has && m_gnt) exp_gnt[w] = 1'b1;
      exp_err = 2'b00;
      if (rsp_due && m_error) exp_err[rsp_who] = 1'b1;
      #1;
      tests++; if (m_req !== has) begin fails++; $display("[TB] FAIL rnd_m_req c%0d got %b want %b", cyc, m_req, has); end
      tests++; if ({s1_gnt, s0_gnt} !== exp_gnt) begin fails++; $display("[TB] FAIL rnd_gnt c%0d got %b want %b", cyc, {s1_gnt, s0_gnt}, exp_gnt); end
      tests++; if ({s1_error, s0_error} !== exp_err) begin fails++; $display("[TB] FAIL rnd_err c%0d got %b want %b", cyc, {s1_error, s0_error}, exp_err); end
      tests++; if (s0_rdata !== m_rdata || s1_rdata !== m_rdata) begin fails++; $display("[TB] FAIL rnd_rdata c%0d got %h/%h want %h", cyc, s0_rdata, s1_rdata, m_rdata); end
      if (has) begin
        tests++;
        if (m_addr !== p_addr[w] || m_wdata !== p_wdata[w] || m_strb !== p_strb[w] || m_wen !== p_wen[w]) begin
          fails++;
          $display("[TB] FAIL rnd_payload c%0d got %h %h %b %b want %h %h %b %b", cyc,
                   m_addr, m_wdata, m_strb, m_wen, p_addr[w], p_wdata[w], p_strb[w], p_wen[w]);
        end
      end
      rsp_due = 0;
      if (has && m_gnt) begin
        pend[w] = 0; served_last = w[0]; held = 0; rsp_due = 1; rsp_who = w[0];
      end else if (has) begin
        held = 1; held_id = w[0];
      end
      @(negedge g_clk);
    end
    idle_inputs();
  endtask

  initial begin
    g_resetn = 0;
    idle_inputs();
    test_reset();
    test_single_grant();
    test_round_robin();
    test_lock_hold();
    test_back_to_back();
    test_reset_mid_lock();
    test_write_payload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
